// File: rtl/char_frame_tx.sv
// rtl/char_frame_tx.sv - payload FIFO plus framer emitting HEADER, payload, TRAILER over a valid/ready handshake
// Optional checksum character before the trailer: define CHAR_FRAME_TX_CSUM_EN.
module char_frame_tx #(
  parameter int          DEPTH     = 8,
  parameter logic [7:0]  HEADER    = 8'h23,
  parameter logic [7:0]  TRAILER   = 8'h3F,
  parameter logic [7:0]  IDLE_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       send,
  output logic       busy,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HEAD = 3'd1,
    S_BODY = 3'd2,
    S_TAIL = 3'd3
`ifdef CHAR_FRAME_TX_CSUM_EN
    , S_CSUM = 3'd4
`endif
  } state_t;

`ifdef CHAR_FRAME_TX_CSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_TAIL;
`endif

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]   count, remain;
  logic            push, pop, accept;
  logic [7:0]      out_nxt;
  logic            out_valid_nxt;
`ifdef CHAR_FRAME_TX_CSUM_EN
  logic [7:0]      csum, csum_nxt;
`endif

  assign full   = (count == CW'(DEPTH));
  assign busy   = (state != S_IDLE);
  assign accept = (state == S_IDLE) && send;
  assign pop    = (state == S_BODY) && out_ready;
  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign push   = wr_en && (!full || pop);
  assign rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
`ifdef CHAR_FRAME_TX_CSUM_EN
  assign csum_nxt = pop ? (csum ^ mem[rd_ptr]) : csum;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remain    <= '0;
      out       <= IDLE_CHAR;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
      rd_ptr    <= rd_ptr_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (accept)   remain <= count;
      else if (pop) remain <= remain - CW'(1);
    end
  end

`ifdef CHAR_FRAME_TX_CSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      csum <= 8'h00;
    else if (accept) csum <= 8'h00;
    else             csum <= csum_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (send) state_nxt = S_HEAD;
      S_HEAD: if (out_ready) state_nxt = (remain != '0) ? S_BODY : S_POST;
      S_BODY: if (out_ready && remain == CW'(1)) state_nxt = S_POST;
`ifdef CHAR_FRAME_TX_CSUM_EN
      S_CSUM: if (out_ready) state_nxt = S_TAIL;
`endif
      S_TAIL: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so out reflects the character
  // owned by the state being entered (FIFO head after any pop this cycle).
  always_comb begin
    out_nxt       = IDLE_CHAR;
    out_valid_nxt = 1'b1;
    case (state_nxt)
      S_HEAD: out_nxt = HEADER;
      S_BODY: out_nxt = mem[rd_ptr_nxt];
`ifdef CHAR_FRAME_TX_CSUM_EN
      S_CSUM: out_nxt = csum_nxt;
`endif
      S_TAIL: out_nxt = TRAILER;
      default: begin
        out_nxt       = IDLE_CHAR;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_char_frame_tx.sv
// tb/tb_char_frame_tx.sv - directed, table-driven bench for char_frame_tx
module tb_char_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       send;
  logic       busy;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;
  byte exp_q[$];

  typedef struct {
    string       data;
    logic [15:0] rdy;
  } vec_t;
  vec_t vecs[5];

  char_frame_tx dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .send(send), .busy(busy), .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic make_exp(input string s);
    byte x;
    int  k;
    x = 8'h00;
    k = (s.len() < 8) ? s.len() : 8;
    exp_q.delete();
    exp_q.push_back(8'h23);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(s[i]);
      x = x ^ s[i];
    end
`ifdef CHAR_FRAME_TX_CSUM_EN
    exp_q.push_back(x);
`endif
    exp_q.push_back(8'h3F);
  endtask

  task automatic write_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      wr_en   = 1'b1;
      wr_data = s[i];
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic do_send();
    send = 1'b1;
    step();
    send = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, out_valid, 1'b0);
    check({name, "_out"}, out, 8'h20);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  // Collects exp_q.size() transferred characters, applying out_ready from rdy.
  task automatic recv_frame(input string name, input logic [15:0] rdy);
    int         got;
    int         cyc;
    logic       pv, pr;
    logic [7:0] po;
    got = 0;
    cyc = 0;
    pv  = 1'b0;
    pr  = 1'b0;
    po  = 8'h00;
    while (got < exp_q.size() && cyc < 200) begin
      out_ready = rdy[cyc % 16];
      if (pv && !pr) check({name, "_hold"}, {out_valid, out}, {1'b1, po});
      if (out_valid && out_ready) begin
        check($sformatf("%s_ch%0d", name, got), out, exp_q[got]);
        got++;
      end
      pv = out_valid;
      pr = out_ready;
      po = out;
      step();
      cyc++;
    end
    if (got < exp_q.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got %0d chars expected %0d", name, got, exp_q.size());
    end
    out_ready = 1'b1;
    check_idle({name, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"BUAA",      16'hFFFF};
    vecs[1] = '{"",          16'hFFFF};
    vecs[2] = '{"abcdefghi", 16'hFFFF};
    vecs[3] = '{"BUAA",      16'h9999};
    vecs[4] = '{"Q?Z",       16'hFFFF};

    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; send = 1'b0; out_ready = 1'b0;
    step();
    step();
    check_idle("reset");
    check("reset_full", full, 1'b0);
    reset = 1'b1;
    step();

    for (int v = 0; v < 5; v++) begin
      write_str(vecs[v].data);
      check($sformatf("v%0d_full", v), full, vecs[v].data.len() >= 8);
      make_exp(vecs[v].data);
      do_send();
      check($sformatf("v%0d_busy", v), busy, 1'b1);
      recv_frame($sformatf("v%0d", v), vecs[v].rdy);
    end

    // Write during HEAD belongs to the next frame; send while busy is ignored.
    write_str("XY");
    do_send();
    out_ready = 1'b0;
    wr_en = 1'b1; wr_data = "Z"; send = 1'b1;
    step();
    wr_en = 1'b0; send = 1'b0;
    check("xy_head_held", out, 8'h23);
    make_exp("XY");
    recv_frame("xy", 16'hFFFF);
    step();
    check_idle("xy_nosend");
    do_send();
    make_exp("Z");
    recv_frame("z", 16'hFFFF);

    // Asynchronous reset in the middle of BODY with a full FIFO.
    write_str("BUAAxxxx");
    do_send();
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    wr_en = 1'b1; wr_data = "k";
    step();
    wr_en = 1'b0;
    check("rst_pre_full", full, 1'b1);
    check("rst_pre_out", out, "U");
    #2 reset = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst_async_full", full, 1'b0);
    step();
    reset = 1'b1;
    step();
    make_exp("");
    do_send();
    recv_frame("post_rst", 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
